seg_p2s64: RTL and testbench

//   Parallel-to-serial shifter for the board's shift-register 7-segment display.

---
 rtl/seg_p2s64.sv | 137 +++++++++++++
 tb/tb_seg_p2s64.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seg_p2s64.sv
// Parallel-to-serial shifter for a shift-register 7-segment display: captures a word on start,
// shifts it MSB-first on a divided serial clock, then pulses the latch enable.
module seg_p2s64 #(
    parameter int DATA_W = 64,
    parameter int HALF   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] par_in,
    output logic              s_clk,
    output logic              s_out,
    output logic              s_en,
    output logic              busy,
    output logic              done
);

    localparam int PH_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int LC_W = $clog2(2 * HALF);
    localparam int BI_W = $clog2(DATA_W);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(2 * HALF - 1);
    localparam logic [BI_W-1:0] BI_TOP  = BI_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [PH_W-1:0]   phase, phase_nxt;
    logic [BI_W-1:0]   bitidx, bitidx_nxt;
    logic [LC_W-1:0]   lcnt, lcnt_nxt;
    logic              s_clk_nxt, s_en_nxt, busy_nxt, done_nxt;

    // The bit on the wire is always the top of the shift register; zero fill means the
    // register is empty (and s_out low) once the last bit has been shifted past.
    assign s_out = shreg[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            phase  <= '0;
            bitidx <= '0;
            lcnt   <= '0;
            s_clk  <= 1'b0;
            s_en   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            shreg  <= shreg_nxt;
            phase  <= phase_nxt;
            bitidx <= bitidx_nxt;
            lcnt   <= lcnt_nxt;
            s_clk  <= s_clk_nxt;
            s_en   <= s_en_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        phase_nxt  = phase;
        bitidx_nxt = bitidx;
        lcnt_nxt   = lcnt;
        s_clk_nxt  = s_clk;
        s_en_nxt   = s_en;
        busy_nxt   = busy;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt  = par_in;
                    phase_nxt  = '0;
                    bitidx_nxt = BI_TOP;
                    lcnt_nxt   = '0;
                    s_clk_nxt  = 1'b0;
                    busy_nxt   = 1'b1;
                    state_nxt  = SHIFT;
                end
            end

            SHIFT: begin
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    if (!s_clk) begin
                        s_clk_nxt = 1'b1;
                    end else begin
                        // End of the high phase: drop the clock and present the next bit together.
                        s_clk_nxt = 1'b0;
                        shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                        if (bitidx == '0) begin
                            s_en_nxt  = 1'b1;
                            lcnt_nxt  = '0;
                            state_nxt = LATCH;
                        end else begin
                            bitidx_nxt = bitidx - 1'b1;
                        end
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end

            LATCH: begin
                if (lcnt == LC_LAST) begin
                    s_en_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    lcnt_nxt = lcnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_p2s64.sv
// Bench for seg_p2s64: an 8-bit/HALF=1 and a 64-bit/HALF=2 instance, each checked cycle by
// cycle against a timing model derived from the transfer's bit and phase arithmetic.
module tb_seg_p2s64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_start = 1'b0;
    logic [7:0]  a_par = '0;
    logic        a_sclk, a_sout, a_sen, a_busy, a_done;
    logic        b_start = 1'b0;
    logic [63:0] b_par = '0;
    logic        b_sclk, b_sout, b_sen, b_busy, b_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seg_p2s64 #(.DATA_W(8), .HALF(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .par_in(a_par),
        .s_clk(a_sclk), .s_out(a_sout), .s_en(a_sen), .busy(a_busy), .done(a_done)
    );

    seg_p2s64 #(.DATA_W(64), .HALF(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .par_in(b_par),
        .s_clk(b_sclk), .s_out(b_sout), .s_en(b_sen), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // {s_clk, s_out, s_en, busy, done} of the chosen instance
    function automatic logic [4:0] outs(input bit sel);
        if (sel) return {b_sclk, b_sout, b_sen, b_busy, b_done};
        return {a_sclk, a_sout, a_sen, a_busy, a_done};
    endfunction

    // Expected outputs k cycles after the accepting edge E0 of word w.
    function automatic logic [4:0] model(input int k, input logic [63:0] w, input int dw, input int h);
        int  per;
        logic sc, so, se, bz, dn;
        per = 2 * h;
        sc = 1'b0;
        so = 1'b0;
        if (k < per * dw) begin
            sc = ((k % per) >= h);
            so = w[dw - 1 - k / per];
        end
        se = (k >= per * dw) && (k < per * (dw + 1));
        bz = (k < per * (dw + 1));
        dn = (k == per * (dw + 1));
        return {sc, so, se, bz, dn};
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [63:0] w);
        if (sel) begin
            b_start = st;
            b_par   = w;
        end else begin
            a_start = st;
            a_par   = w[7:0];
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One transfer. started: E0 already happened (back-to-back). hold: keep start high and
    // present nw for the next transfer in the done cycle. rst_at>0: reset lands at E0+rst_at.
    task automatic xfer(input bit sel, input logic [63:0] w, input bit started,
                        input bit hold, input logic [63:0] nw, input int rst_at);
        int dw, h, total, rises;
        logic [63:0] cap, junk;
        logic prev_sclk;
        logic [4:0] o;
        string nm;
        dw    = sel ? 64 : 8;
        h     = sel ? 2 : 1;
        total = 2 * h * (dw + 1);
        rises = 0;
        cap   = '0;
        prev_sclk = 1'b0;
        nm = sel ? "b" : "a";
        junk = sel ? rnd64() : (rnd64() & 64'hff);
        if (!started) begin
            drive(sel, 1'b1, w);
            @(negedge clk);
        end
        for (int k = 0; k <= total; k++) begin
            o = outs(sel);
            if (rst_at > 0 && k == rst_at) begin
                check($sformatf("%s rst_abort k=%0d", nm, k), {59'd0, o}, 64'd0);
                rst = 1'b0;
                for (int j = 1; j <= 3; j++) begin
                    @(negedge clk);
                    check($sformatf("%s post_rst +%0d", nm, j), {59'd0, outs(sel)}, 64'd0);
                end
                return;
            end
            check($sformatf("%s k=%0d", nm, k), {59'd0, o}, {59'd0, model(k, w, dw, h)});
            if (o[4] && !prev_sclk) begin
                cap = {cap[62:0], o[3]};
                rises++;
            end
            prev_sclk = o[4];
            if (!hold) begin
                if (k == 0) drive(sel, 1'b0, w);
                if (k == 3) drive(sel, 1'b0, junk);
                if (k == 5) drive(sel, 1'b1, ~w);
                if (k == 6) drive(sel, 1'b0, junk);
            end else if (k == total) begin
                drive(sel, 1'b1, nw);
            end
            if (rst_at > 0 && k == rst_at - 1) rst = 1'b1;
            @(negedge clk);
        end
        check($sformatf("%s rises", nm), 64'(rises), 64'(dw));
        check($sformatf("%s serial_word", nm), cap, w);
        if (!hold) check($sformatf("%s idle_after", nm), {59'd0, outs(sel)}, 64'd0);
    endtask

    initial begin
        logic [63:0] w1, w2;
        bit sel;

        repeat (2) @(negedge clk);
        check("a reset", {59'd0, outs(1'b0)}, 64'd0);
        check("b reset", {59'd0, outs(1'b1)}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        xfer(1'b0, 64'hA5, 1'b0, 1'b0, 64'd0, 0);
        xfer(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'd0, 0);

        // start held high across two transfers
        w1 = rnd64() & 64'hff;
        w2 = rnd64() & 64'hff;
        xfer(1'b0, w1, 1'b0, 1'b1, w2, 0);
        xfer(1'b0, w2, 1'b1, 1'b0, 64'd0, 0);
        w1 = rnd64();
        w2 = rnd64();
        xfer(1'b1, w1, 1'b0, 1'b1, w2, 0);
        xfer(1'b1, w2, 1'b1, 1'b0, 64'd0, 0);

        for (int i = 0; i < 6; i++) begin
            sel = 1'($urandom_range(0, 1));
            w1  = sel ? rnd64() : (rnd64() & 64'hff);
            xfer(sel, w1, 1'b0, 1'b0, 64'd0, 0);
        end

        // reset mid-transfer, then a clean transfer
        xfer(1'b0, 64'h3C, 1'b0, 1'b0, 64'd0, 10);
        xfer(1'b0, 64'hC3, 1'b0, 1'b0, 64'd0, 0);
        xfer(1'b1, rnd64(), 1'b0, 1'b0, 64'd0, 10);
        xfer(1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
